// File: rtl/slot_phase_bank_writer.sv
// Slot/phase bank writer: 3-bit slot entries, one-hot phase select,
// valid/ready write port and a one-slot-per-cycle clear sweep.
module slot_phase_bank_writer #(
    parameter int NUM_SLOTS = 14,
    parameter int SLOT_W    = 4
) (
    input  logic                   CK,
    input  logic                   RN,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [SLOT_W-1:0]      wr_slot,
    input  logic [2:0]             wr_data,
    input  logic                   clr_req,
    input  logic                   phase_adv,
    output logic [2:0]             phase_sel,
    output logic [3*NUM_SLOTS-1:0] slot_bits,
    output logic [NUM_SLOTS-1:0]   sel_bits,
    output logic                   busy,
    output logic                   err_slot
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    localparam logic [SLOT_W:0]   LP_NUM  = (SLOT_W+1)'(NUM_SLOTS);
    localparam logic [SLOT_W-1:0] LP_LAST = SLOT_W'(NUM_SLOTS - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SLOT_W-1:0] r_ptr;
    logic [SLOT_W-1:0] w_ptr_nxt;
    logic [2:0]        r_slot [NUM_SLOTS];
    logic [2:0]        w_slot_nxt [NUM_SLOTS];
    logic [2:0]        r_phase;
    logic              r_busy;
    logic              r_ready;
    logic              r_err;
    logic              w_acc;
    logic              w_in_rng;
    logic              w_sweep;

    assign w_acc    = wr_valid & r_ready;
    assign w_in_rng = ({1'b0, wr_slot} < LP_NUM);
    assign w_sweep  = (r_state == SWEEP);

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        unique case (r_state)
            IDLE: begin
                if (clr_req) begin
                    w_state_nxt = SWEEP;
                    w_ptr_nxt   = '0;
                end
            end
            SWEEP: begin
                w_ptr_nxt = r_ptr + 1'b1;
                if (r_ptr == LP_LAST) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    // Writes only land in IDLE, so they never race the sweep clear.
    always_comb begin
        for (int k = 0; k < NUM_SLOTS; k++) begin
            w_slot_nxt[k] = r_slot[k];
            if (w_acc && w_in_rng && wr_slot == SLOT_W'(k))
                w_slot_nxt[k] = wr_data;
            if (w_sweep && r_ptr == SLOT_W'(k))
                w_slot_nxt[k] = 3'b000;
        end
    end

    always_ff @(posedge CK) begin
        if (!RN) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_phase <= 3'b001;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            for (int k = 0; k < NUM_SLOTS; k++)
                r_slot[k] <= 3'b000;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_busy  <= (w_state_nxt == SWEEP);
            r_ready <= (w_state_nxt == IDLE);
            if (phase_adv)
                r_phase <= {r_phase[1:0], r_phase[2]};
            if (w_acc && !w_in_rng)
                r_err <= 1'b1;
            for (int k = 0; k < NUM_SLOTS; k++)
                r_slot[k] <= w_slot_nxt[k];
        end
    end

    always_comb begin
        slot_bits = '0;
        sel_bits  = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            slot_bits[3*k +: 3] = r_slot[k];
            sel_bits[k]         = |(r_slot[k] & r_phase);
        end
    end

    assign phase_sel = r_phase;
    assign busy      = r_busy;
    assign wr_ready  = r_ready;
    assign err_slot  = r_err;

endmodule

// File: tb/tb_slot_phase_bank_writer.sv
// Directed bench for slot_phase_bank_writer: vector table for
// writes/phase rotation plus hand sequences for sweep and reset.
module tb_slot_phase_bank_writer;

    localparam int N  = 14;
    localparam int SW = 4;
    localparam int BW = 3 * N;

    logic          CK = 1'b0;
    logic          RN;
    logic          wr_valid;
    logic          wr_ready;
    logic [SW-1:0] wr_slot;
    logic [2:0]    wr_data;
    logic          clr_req;
    logic          phase_adv;
    logic [2:0]    phase_sel;
    logic [BW-1:0] slot_bits;
    logic [N-1:0]  sel_bits;
    logic          busy;
    logic          err_slot;

    int errors = 0;
    int checks = 0;

    slot_phase_bank_writer #(.NUM_SLOTS(N), .SLOT_W(SW)) dut (
        .CK(CK), .RN(RN),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_slot(wr_slot), .wr_data(wr_data),
        .clr_req(clr_req), .phase_adv(phase_adv),
        .phase_sel(phase_sel), .slot_bits(slot_bits),
        .sel_bits(sel_bits), .busy(busy), .err_slot(err_slot)
    );

    always #5 CK = ~CK;

    typedef struct {
        logic          rn;
        logic          wv;
        logic [SW-1:0] slot;
        logic [2:0]    data;
        logic          clr;
        logic          adv;
        logic [2:0]    e_phase;
        logic [BW-1:0] e_bank;
        logic [N-1:0]  e_sel;
        logic          e_busy;
        logic          e_err;
        logic          e_rdy;
    } vec_t;

    vec_t vt [11];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rn, input logic wv,
                         input logic [SW-1:0] s, input logic [2:0] d,
                         input logic clr, input logic adv);
        RN = rn; wr_valid = wv; wr_slot = s; wr_data = d;
        clr_req = clr; phase_adv = adv;
    endtask

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    function automatic vec_t mk(logic rn, logic wv, logic [SW-1:0] s,
                                logic [2:0] d, logic clr, logic adv,
                                logic [2:0] ep, logic [BW-1:0] eb,
                                logic [N-1:0] es, logic ebz,
                                logic ee, logic er);
        vec_t v;
        v.rn = rn; v.wv = wv; v.slot = s; v.data = d;
        v.clr = clr; v.adv = adv; v.e_phase = ep; v.e_bank = eb;
        v.e_sel = es; v.e_busy = ebz; v.e_err = ee; v.e_rdy = er;
        return v;
    endfunction

    logic [BW-1:0] b5, b25a, b25b, exp_bank;
    logic [BW-1:0] ones;

    initial begin
        b5   = BW'(5) << 15;
        b25a = b5 | (BW'(3) << 6);
        b25b = b5 | (BW'(6) << 6);
        ones = '1;
        vt[0]  = mk(0,0,0,0,0,0, 3'b001, '0, '0, 0,0,0);
        vt[1]  = mk(0,0,0,0,0,0, 3'b001, '0, '0, 0,0,0);
        vt[2]  = mk(1,0,0,0,0,0, 3'b001, '0, '0, 0,0,1);
        vt[3]  = mk(1,1,5,3'b101,0,0, 3'b001, b5, N'(1)<<5, 0,0,1);
        vt[4]  = mk(1,0,0,0,0,1, 3'b010, b5, '0, 0,0,1);
        vt[5]  = mk(1,0,0,0,0,1, 3'b100, b5, N'(1)<<5, 0,0,1);
        vt[6]  = mk(1,0,0,0,0,1, 3'b001, b5, N'(1)<<5, 0,0,1);
        vt[7]  = mk(1,1,2,3'b011,0,0, 3'b001, b25a, N'('h24), 0,0,1);
        vt[8]  = mk(1,1,2,3'b110,0,0, 3'b001, b25b, N'('h20), 0,0,1);
        vt[9]  = mk(1,1,15,3'b111,0,0, 3'b001, b25b, N'('h20), 0,1,1);
        vt[10] = mk(1,0,0,0,0,0, 3'b001, b25b, N'('h20), 0,1,1);

        drive(0,0,0,0,0,0);
        for (int i = 0; i < 11; i++) begin
            drive(vt[i].rn, vt[i].wv, vt[i].slot, vt[i].data,
                  vt[i].clr, vt[i].adv);
            step();
            chk($sformatf("v%0d phase", i), 64'(phase_sel), 64'(vt[i].e_phase));
            chk($sformatf("v%0d bank", i),  64'(slot_bits), 64'(vt[i].e_bank));
            chk($sformatf("v%0d sel", i),   64'(sel_bits),  64'(vt[i].e_sel));
            chk($sformatf("v%0d busy", i),  64'(busy),      64'(vt[i].e_busy));
            chk($sformatf("v%0d err", i),   64'(err_slot),  64'(vt[i].e_err));
            chk($sformatf("v%0d rdy", i),   64'(wr_ready),  64'(vt[i].e_rdy));
        end

        // Full sweep: fill with 111, clear with a coincident write.
        for (int k = 0; k < N; k++) begin
            drive(1,1,SW'(k),3'b111,0,0);
            step();
        end
        chk("fill bank", 64'(slot_bits), 64'(ones));
        drive(1,1,4'd0,3'b111,1,0);
        step();
        chk("sw0 busy", 64'(busy), 64'd1);
        chk("sw0 rdy", 64'(wr_ready), 64'd0);
        chk("sw0 bank", 64'(slot_bits), 64'(ones));
        exp_bank = ones;
        for (int c = 1; c <= N; c++) begin
            drive(1,1,4'd3,3'b111,(c == 3 || c == N),0);
            step();
            exp_bank[3*(c-1) +: 3] = 3'b000;
            chk($sformatf("sw%0d bank", c), 64'(slot_bits), 64'(exp_bank));
            chk($sformatf("sw%0d busy", c), 64'(busy), 64'(c < N));
            chk($sformatf("sw%0d rdy", c), 64'(wr_ready), 64'(c == N));
        end
        chk("sweep end err", 64'(err_slot), 64'd1);
        drive(1,0,0,0,0,0);
        step();
        chk("post sweep busy", 64'(busy), 64'd0);
        chk("post sweep bank", 64'(slot_bits), 64'd0);

        // Reset mid-sweep at phase 100.
        drive(1,1,4'd3,3'b111,0,1);
        step();
        drive(1,1,4'd7,3'b010,0,1);
        step();
        chk("pre rst phase", 64'(phase_sel), 64'h4);
        chk("pre rst sel", 64'(sel_bits), 64'(N'(1)<<3));
        drive(1,0,0,0,1,0);
        step();
        for (int c = 1; c < 6; c++) begin
            drive(1,0,0,0,1,0);
            step();
        end
        chk("mid busy", 64'(busy), 64'd1);
        drive(0,0,0,0,0,1);
        step();
        chk("rst phase", 64'(phase_sel), 64'h1);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst bank", 64'(slot_bits), 64'd0);
        chk("rst err", 64'(err_slot), 64'd0);
        chk("rst rdy", 64'(wr_ready), 64'd0);
        drive(1,0,0,0,0,0);
        step();
        chk("rel rdy", 64'(wr_ready), 64'd1);
        chk("rel busy", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/slot_phase_bank_writer.md
Name: slot_phase_bank_writer

Overview:
Writer side of the slot/phase match interface in the s38417 cone family. Holds a bank of 3-bit slot entries, one bit per phase, and drives the one-hot phase-select lines. The downstream matcher reads the bank through these lines. Entries are written through a valid/ready port. A sweep engine clears the bank one slot per cycle on request. Per-slot selected-phase bits are presented for the matcher.

Parameters:
NUM_SLOTS, 14, number of 3-bit slot entries (2..16)
SLOT_W, 4, slot index width; must satisfy 2^SLOT_W >= NUM_SLOTS

Ports:
CK  in  1  clock, all state updates on rising edge
RN  in  1  synchronous active-low reset
wr_valid  in  1  write request valid
wr_ready  out  1  writer can accept this cycle
wr_slot  in  SLOT_W  target slot index
wr_data  in  3  entry bits {phase2,phase1,phase0}
clr_req  in  1  pulse: start bank clear sweep
phase_adv  in  1  advance phase select one step
phase_sel  out  3  one-hot phase select to matcher (bit0, bit1, bit2)
slot_bits  out  3*NUM_SLOTS  raw bank contents; slot k at [3k+2:3k]
sel_bits  out  NUM_SLOTS  bit k = slot k bit at the active phase
busy  out  1  sweep in progress
err_slot  out  1  sticky: accepted write had wr_slot >= NUM_SLOTS

Behaviour:
- Reset: on a rising CK edge with RN=0, the block enters IDLE and sets phase_sel=3'b001. All entries, err_slot and busy clear to 0. The sweep pointer clears to 0. This applies from any state, including mid-sweep.
- wr_ready is a registered 0 during the reset cycle. It is 1 only in IDLE.
- Write transfer: wr_valid & wr_ready at a rising edge.
  - The entry is updated at that same edge, so slot_bits and sel_bits reflect it the next cycle (latency 1).
  - Back-to-back writes are accepted every cycle.
  - Writes to the same slot: the last one wins.
- Out-of-range slot (wr_slot >= NUM_SLOTS): the transfer completes (handshake honoured) but no entry changes, and err_slot sets to 1. err_slot clears only on reset.
- FSM states: IDLE, SWEEP.
  - IDLE -> SWEEP when clr_req=1. On that edge the pointer loads 0, busy goes to 1 and wr_ready goes to 0.
  - If clr_req and a valid write coincide in IDLE, the write is accepted first and the sweep starts on the same edge. The written slot is then cleared later by the sweep.
  - SWEEP: each cycle, clear slot[pointer] and increment the pointer.
  - When pointer = NUM_SLOTS-1, that slot is cleared, the FSM returns to IDLE, and busy returns to 0. The sweep takes exactly NUM_SLOTS cycles; wr_ready returns to 1 the following cycle.
  - clr_req in SWEEP is ignored (no restart).
- Phase select:
  - Each phase_adv=1 at an edge rotates phase_sel 001 -> 010 -> 100 -> 001.
  - It rotates in any state, independent of writes and sweep.
  - phase_sel is always exactly one-hot.
- sel_bits[k] = OR over j of (slot_k[j] & phase_sel[j]). It is purely combinational from registered state, so there is no extra latency.
- All outputs are registered or are functions of registers only; there is no combinational path from any input to any output.

Test Plan:
1. Reset release: RN=0 for 2 cycles, then 1 -> phase_sel=001, slot_bits=0, sel_bits=0, busy=0, err_slot=0, wr_ready=1 after the first post-reset edge.
2. Write slot 5 with data 3'b101 at phase 001 -> next cycle slot_bits[17:15]=101 and sel_bits[5]=1. After 1 phase_adv sel_bits[5]=0; after 2, sel_bits[5]=1.
3. Back-to-back writes to slot 2 (011, then 110), with phase_adv held 0 -> slot 2 = 110 after cycle 2, and sel_bits[2]=0 at phase 001.
4. Write wr_slot=15 with NUM_SLOTS=14 -> handshake completes, slot_bits unchanged, err_slot=1 and stays 1 until RN=0.
5. Fill all slots with 111, then pulse clr_req -> busy=1 and wr_ready=0 for exactly 14 cycles; slot k reads 0 after sweep cycle k; the bank is all-zero at the end; wr_ready returns to 1.
6. Assert RN=0 at sweep cycle 6 with phase_sel=100 -> next cycle IDLE, busy=0, phase_sel=001, bank all-zero. clr_req during a sweep must not extend the sweep.
